// File: rtl/stepdown_drv_pkg.sv
// Shared types for the stepdown gate-drive sequencer.
// Covers the state encoding, the default counter width and a dead-time helper.
package stepdown_drv_pkg;

  localparam int STEP_CNT_W = 8;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    LS_ON   = 3'd1,
    DT_LH   = 3'd2,
    HS_ON   = 3'd3,
    DT_HL   = 3'd4,
    FAULT   = 3'd5,
    LS_IDLE = 3'd6
  } drv_state_t;

  function automatic logic is_dead_time(
    input drv_state_t s
  );
    return (s == DT_LH) || (s == DT_HL);
  endfunction

endpackage

// File: rtl/stepdown_dwell_cnt.sv
// Clearable saturating up-counter.
// Used for the per-state dwell time and the overcurrent trip count.
module stepdown_dwell_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt < lim)) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/stepdown_gate_seq.sv
// Non-overlapping HS/LS gate-drive sequencer with dead time and OCP fault latch.
// Define STEPDOWN_DIODE_EMU_EN to add the zero-cross LS_IDLE state.
module stepdown_gate_seq
  import stepdown_drv_pkg::*;
#(
  parameter int CNT_W     = STEP_CNT_W,
  parameter int DT_CYC    = 4,
  parameter int TMIN_ON   = 6,
  parameter int TMIN_OFF  = 6,
  parameter int BLANK_CYC = 3,
  parameter int FAULT_LIM = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CELV,
  input  logic       CELG,
  input  logic       SUB,
  input  logic       en,
  input  logic       pwm_in,
  input  logic       ocp,
  input  logic       zc,
  output logic       hs_en,
  output logic       ls_en,
  output logic       drv_ok,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] DT_LAST  = CNT_W'(DT_CYC - 1);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TMIN_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(TMIN_OFF - 1);
  localparam logic [CNT_W-1:0] BLANK    = CNT_W'(BLANK_CYC);
  localparam logic [CNT_W-1:0] LIM      = CNT_W'(FAULT_LIM);
  localparam logic [CNT_W-1:0] ONES     = '1;

  drv_state_t       state;
  drv_state_t       nxt;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] trips;
  logic             trip_inc;
  logic             trip_clr;
  logic             dwell_clr;
  logic             hs_nxt;
  logic             ls_nxt;
  logic             unused_ok;

  // Supply/substrate pins are connectivity only.
  assign unused_ok = &{1'b0, CELV, CELG, SUB, zc};

  assign dwell_clr = (nxt != state);
  assign state_o   = state;

  stepdown_dwell_cnt #(.W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .inc   (1'b1),
    .lim   (ONES),
    .cnt   (dwell)
  );

  stepdown_dwell_cnt #(.W(CNT_W)) u_trips (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (trip_clr),
    .inc   (trip_inc),
    .lim   (LIM),
    .cnt   (trips)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt      = state;
    trip_inc = 1'b0;
    trip_clr = 1'b0;
    if (!en) begin
      nxt      = OFF;
      trip_clr = 1'b1;
    end else begin
      unique case (state)
        OFF: nxt = LS_ON;
        LS_ON: begin
          if (pwm_in && (dwell >= OFF_LAST)) begin
            nxt = DT_LH;
          end
`ifdef STEPDOWN_DIODE_EMU_EN
          else if (zc && (dwell >= OFF_LAST)) begin
            nxt = LS_IDLE;
          end
`endif
        end
        DT_LH: begin
          if (dwell >= DT_LAST) nxt = HS_ON;
        end
        HS_ON: begin
          // Current limit beats minimum on-time once blanking expires.
          if (ocp && (dwell >= BLANK)) begin
            nxt      = DT_HL;
            trip_inc = 1'b1;
          end else if (!pwm_in && (dwell >= ON_LAST)) begin
            nxt      = DT_HL;
            trip_clr = 1'b1;
          end
        end
        DT_HL: begin
          if (dwell >= DT_LAST) begin
            nxt = (trips >= LIM) ? FAULT : LS_ON;
          end
        end
        FAULT: nxt = FAULT;
`ifdef STEPDOWN_DIODE_EMU_EN
        LS_IDLE: begin
          if (pwm_in) nxt = DT_LH;
        end
`endif
        default: nxt = OFF;
      endcase
    end
  end

  always_comb begin
    hs_nxt = 1'b0;
    ls_nxt = 1'b0;
    unique case (1'b1)
      is_dead_time(nxt): begin
        hs_nxt = 1'b0;
        ls_nxt = 1'b0;
      end
      (nxt == HS_ON): hs_nxt = 1'b1;
      (nxt == LS_ON): ls_nxt = 1'b1;
      default: begin
        hs_nxt = 1'b0;
        ls_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_en  <= 1'b0;
      ls_en  <= 1'b0;
      drv_ok <= 1'b0;
      fault  <= 1'b0;
    end else begin
      hs_en  <= hs_nxt;
      ls_en  <= ls_nxt;
      drv_ok <= en && (nxt != FAULT);
      fault  <= (nxt == FAULT);
    end
  end

endmodule

// File: doc/stepdown_gate_seq.md
Name: stepdown_gate_seq

Overview:
- Synchronous gate-drive sequencer for the stepdown loop driver.
- Sits directly upstream of the driver nand3 cells.
- Converts the loop PWM request into non-overlapping high-side/low-side enables with programmable dead time, minimum on-times, leading-edge blanked cycle-by-cycle current limit, and a latched fault after repeated overcurrent trips.
- Outputs hs_en, ls_en and drv_ok feed the driver nand3 i0/i1/i2 inputs.

Parameters:
- CNT_W, 8, width of all internal cycle counters.
- DT_CYC, 4, dead-time cycles with both switches off; legal range 1..2^CNT_W-1.
- TMIN_ON, 6, minimum high-side on cycles before pwm_in low is honoured.
- TMIN_OFF, 6, minimum low-side on cycles before pwm_in high is honoured.
- BLANK_CYC, 3, cycles after HS_ON entry during which ocp is ignored; must be < TMIN_ON.
- FAULT_LIM, 4, consecutive overcurrent-terminated HS periods that latch a fault.

Ports:
- clk  input  1  sequencer clock
- rst_n  input  1  asynchronous active-low reset
- CELV  input  1  driver supply; connectivity only, no logic function
- CELG  input  1  driver ground; connectivity only
- SUB  input  1  substrate; connectivity only
- en  input  1  converter enable, synchronous to clk
- pwm_in  input  1  loop PWM request (1 = high side on)
- ocp  input  1  overcurrent comparator, synchronous to clk
- zc  input  1  inductor zero-cross; used only with the optional feature
- hs_en  output  1  high-side enable, registered
- ls_en  output  1  low-side enable, registered
- drv_ok  output  1  driver permitted; registered; equals en & ~fault
- fault  output  1  latched overcurrent fault
- state_o  output  3  current state encoding, for debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values:
  - State OFF.
  - All counters 0.
  - hs_en=0, ls_en=0, drv_ok=0, fault=0.
- Output timing: hs_en and ls_en are decoded from the next state and registered, so there is 1-cycle latency from a state decision. hs_en and ls_en are never both 1 in any cycle; this is an invariant.
- States: OFF, LS_ON, DT_LH, HS_ON, DT_HL, FAULT.
- OFF: both enables 0. en=1 moves to LS_ON (bootstrap precharge). On entry to any state its dwell counter clears.
- LS_ON: ls_en=1. Once the dwell counter reaches TMIN_OFF-1 and pwm_in=1, move to DT_LH.
- DT_LH: both enables 0 for exactly DT_CYC cycles, then HS_ON. pwm_in changes are ignored; the transition is committed.
- HS_ON: hs_en=1.
  - pwm_in=0 with dwell counter >= TMIN_ON-1 moves to DT_HL.
  - ocp=1 with dwell counter >= BLANK_CYC moves to DT_HL immediately, overriding TMIN_ON, and increments trip_cnt.
- DT_HL: both enables 0 for exactly DT_CYC cycles, then LS_ON.
- trip_cnt:
  - Clears when an HS_ON period exits through pwm_in without a trip.
  - Saturates at FAULT_LIM.
  - Reaching FAULT_LIM routes DT_HL to FAULT instead of LS_ON; fault sets when FAULT is entered.
- FAULT: both enables 0 and fault=1. Exit only when en=0, which goes to OFF, clears fault and clears trip_cnt.
- en=0 in any state: next state is OFF and both enables are 0 the next cycle. en wins over simultaneous ocp, pwm_in and zc.
- ocp outside HS_ON is ignored. ocp inside the blanking window is ignored and not counted.
- Counters saturate and never wrap.
- rst_n asserted mid-period drops both enables asynchronously.

Optional Feature:
- Macro: STEPDOWN_DIODE_EMU_EN.
- Defined:
  - In LS_ON, zc=1 after TMIN_OFF is satisfied moves to an added state LS_IDLE with both enables 0. This adds a seventh state; state_o is 3 bits wide and holds all seven encodings.
  - LS_IDLE moves to DT_LH when pwm_in=1. The dead time is still applied.
- Undefined: the zc input is ignored, LS_IDLE does not exist, and LS_ON holds until pwm_in=1.

Decomposition:
- Package stepdown_drv_pkg holds:
  - the state enum with fixed encodings, OFF=0, LS_ON=1, DT_LH=2, HS_ON=3, DT_HL=4, FAULT=5, LS_IDLE=6;
  - the default CNT_W;
  - an is_dead_time() helper.
- One sub-module, stepdown_dwell_cnt: a clearable saturating counter used for dwell and trip_cnt.

Test Plan:
- Reset/enable: release rst_n with en=1, pwm_in=0 -> cycle 1 ls_en=1, drv_ok=1, hs_en=0 and state_o=1.
- Normal PWM with DT_CYC=4: hold pwm_in high from LS_ON cycle 6 -> ls_en falls, exactly 4 cycles with both low, then hs_en=1. The falling pwm_in edge is mirrored by 4 dead cycles, then ls_en=1.
- Minimum on: pwm_in high for 2 cycles only -> hs_en stays 1 for TMIN_ON=6 cycles before DT_HL.
- Blanking/current limit: ocp=1 on HS_ON cycle 1 -> ignored. ocp=1 on HS cycle 3 -> DT_HL next cycle and trip_cnt=1.
- Fault latch: 4 consecutive tripped periods -> fault=1, drv_ok=0, both enables 0 with pwm toggling. Then en=0 for 1 cycle followed by en=1 -> fault=0 and LS_ON.
- Priority and optional feature: en=0 coincident with ocp during HS_ON -> OFF next cycle with trip_cnt=0. With STEPDOWN_DIODE_EMU_EN, zc=1 in LS_ON after 6 cycles -> ls_en=0 and state_o=6.
